// File: rtl/eth_rx_fcs_check.sv
// Ethernet receive FCS checker.
// Consumes one frame (DA through FCS) a byte per accepted cycle, runs the
// reflected CRC-32 over every byte and judges the frame by the residue left
// in the register. Payload bytes are forwarded through a 4-byte delay line so
// that the trailing FCS is never emitted. One status pulse follows each frame.
module eth_rx_fcs_check #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int LEN_W   = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  input  logic             in_err,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             stat_valid,
  output logic             stat_crc_err,
  output logic             stat_runt,
  output logic             stat_oversize,
  output logic             stat_phy_err,
  output logic [LEN_W-1:0] stat_len
);

  localparam int               DATA_W      = 8;
  localparam int               DLY_DEPTH   = 4;
  localparam logic [31:0]      CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0]      CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0]      CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [LEN_W-1:0] LEN_SAT     = '1;
  localparam logic [2:0]       FILL_FULL   = 3'(DLY_DEPTH);
  localparam logic [2:0]       FILL_LAST   = 3'(DLY_DEPTH - 1);

  // END is not a resting state: the in_last cycle finalises the frame and
  // drops straight back to IDLE so a following frame can start at once.
  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_STREAM
  } state_t;

  // One byte of reflected CRC-32, LSB of the byte first, fully unrolled.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [DATA_W-1:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < DATA_W; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ CRC_POLY;
      else             c = c >> 1;
    end
    return c;
  endfunction

  // Byte count increment that sticks at all-ones instead of wrapping.
  function automatic logic [LEN_W-1:0] len_sat_inc(input logic [LEN_W-1:0] n);
    return (n == LEN_SAT) ? n : n + 1'b1;
  endfunction

  state_t                         state_p0;
  logic [31:0]                    crc_p0;
  logic [LEN_W-1:0]               len_p0;
  logic [2:0]                     fill_p0;
  logic                           err_p0;
  logic [DLY_DEPTH-1:0][DATA_W-1:0] dly_p0;

  logic [31:0]      crc_nxt;
  logic [LEN_W-1:0] len_nxt;
  logic             err_nxt;
  logic             emit;

  // ---- stage p0: per-byte next values (CRC, count, sticky error) ----
  assign crc_nxt = crc32_byte(crc_p0, in_data);
  assign len_nxt = len_sat_inc(len_p0);
  assign err_nxt = err_p0 | in_err;
  assign emit    = (state_p0 == S_STREAM);

  // Frame control, CRC accumulation and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0      <= S_IDLE;
      crc_p0        <= CRC_INIT;
      len_p0        <= '0;
      fill_p0       <= '0;
      err_p0        <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_last      <= 1'b0;
      stat_valid    <= 1'b0;
      stat_crc_err  <= 1'b0;
      stat_runt     <= 1'b0;
      stat_oversize <= 1'b0;
      stat_phy_err  <= 1'b0;
      stat_len      <= '0;
    end else begin
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      stat_valid <= 1'b0;
      if (in_valid) begin
        // The delay line is full: the oldest byte is payload, not FCS.
        if (emit) begin
          out_valid <= 1'b1;
          out_data  <= dly_p0[DLY_DEPTH-1];
          out_last  <= in_last;
        end
        if (in_last) begin
          // ---- stage p1: frame verdict, registered with the last byte ----
          stat_valid    <= 1'b1;
          stat_crc_err  <= (crc_nxt != CRC_RESIDUE);
          stat_runt     <= (32'(len_nxt) < 32'(MIN_LEN));
          stat_oversize <= (32'(len_nxt) > 32'(MAX_LEN));
          stat_phy_err  <= err_nxt;
          stat_len      <= len_nxt;
          crc_p0        <= CRC_INIT;
          len_p0        <= '0;
          fill_p0       <= '0;
          err_p0        <= 1'b0;
          state_p0      <= S_IDLE;
        end else begin
          crc_p0 <= crc_nxt;
          len_p0 <= len_nxt;
          err_p0 <= err_nxt;
          if (fill_p0 != FILL_FULL) fill_p0 <= fill_p0 + 3'd1;
          case (state_p0)
            S_IDLE:   state_p0 <= S_FILL;
            S_FILL:   state_p0 <= (fill_p0 == FILL_LAST) ? S_STREAM : S_FILL;
            S_STREAM: state_p0 <= S_STREAM;
            default:  state_p0 <= S_IDLE;
          endcase
        end
      end
    end
  end

  // Byte delay line; its contents are only meaningful under the fill count.
  always_ff @(posedge clk) begin
    if (in_valid) dly_p0 <= {dly_p0[DLY_DEPTH-2:0], in_data};
  end

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Bench for eth_rx_fcs_check: table of directed frames, a reset-abort
// sequence and a batch of random frames, all scored against a byte-queue
// model that derives payload and status from the frame contents.
module tb_eth_rx_fcs_check;

  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;
  localparam int LEN_W   = 12;
  localparam logic [31:0] POLY = 32'hEDB8_8320;

  localparam int K_DIGITS     = 0;
  localparam int K_DIGITS_BAD = 1;
  localparam int K_ZERO       = 2;
  localparam int K_RAW        = 3;
  localparam int K_RAND       = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_last, in_err;
  logic [7:0]       in_data;
  logic             out_valid, out_last;
  logic [7:0]       out_data;
  logic             stat_valid, stat_crc_err, stat_runt, stat_oversize, stat_phy_err;
  logic [LEN_W-1:0] stat_len;

  eth_rx_fcs_check #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_err(in_err),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .stat_valid(stat_valid), .stat_crc_err(stat_crc_err), .stat_runt(stat_runt),
    .stat_oversize(stat_oversize), .stat_phy_err(stat_phy_err), .stat_len(stat_len)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] d; logic last; } ob_t;
  typedef struct { logic crc_err; logic runt; logic over; logic phy; logic [LEN_W-1:0] len; } st_t;
  typedef struct { int kind; int n; int err_at; int gap; int reps;
                   int e_crc; int e_runt; int e_over; int e_phy; int e_len; } vec_t;

  ob_t exp_out[$], act_out[$];
  st_t exp_st[$], act_st[$];
  logic [7:0]  fr[$];
  logic [31:0] crc_tab [256];
  vec_t        vt [12];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Table-driven CRC-32 (reflected), register value after fr[0..n-1].
  function automatic logic [31:0] crc_over(input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) c = crc_tab[c[7:0] ^ fr[i]] ^ (c >> 8);
    return c;
  endfunction

  task automatic append_fcs();
    logic [31:0] c;
    c = ~crc_over(fr.size());
    fr.push_back(c[7:0]);  fr.push_back(c[15:8]);
    fr.push_back(c[23:16]); fr.push_back(c[31:24]);
  endtask

  task automatic build(input int kind, input int n);
    fr.delete();
    case (kind)
      K_DIGITS, K_DIGITS_BAD: begin
        for (int i = 0; i < 9; i++) fr.push_back(8'(8'h31 + i));
        fr.push_back(8'h26); fr.push_back(8'h39); fr.push_back(8'hF4); fr.push_back(8'hCB);
        if (kind == K_DIGITS_BAD) fr[4] = 8'h34;
      end
      K_ZERO: begin
        for (int i = 0; i < n - 4; i++) fr.push_back(8'h00);
        append_fcs();
      end
      K_RAW: begin
        fr.push_back(8'hAA); fr.push_back(8'hBB); fr.push_back(8'hCC);
      end
      default: begin
        for (int i = 0; i < n - 4; i++) fr.push_back(8'($urandom));
        append_fcs();
      end
    endcase
  endtask

  // Expected payload bytes go straight to the queue; status is returned.
  task automatic model_frame(input bit phy, output st_t s);
    int n;
    ob_t o;
    logic [31:0] fcs;
    n = fr.size();
    if (n >= 5)
      for (int i = 0; i < n - 4; i++) begin
        o.d = fr[i]; o.last = (i == n - 5);
        exp_out.push_back(o);
      end
    if (n >= 4) begin
      fcs = {fr[n-1], fr[n-2], fr[n-3], fr[n-4]};
      s.crc_err = ((~crc_over(n - 4)) != fcs);
    end else begin
      s.crc_err = (crc_over(n) != 32'hDEBB_20E3);
    end
    s.runt = (n < MIN_LEN);
    s.over = (n > MAX_LEN);
    s.phy  = phy;
    s.len  = (n > (1 << LEN_W) - 1) ? LEN_W'((1 << LEN_W) - 1) : LEN_W'(n);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; in_last = 1'b0; in_err = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Gaps only between bytes, so consecutive calls give back-to-back frames.
  task automatic drive_frame(input int gap, input int err_at);
    for (int i = 0; i < fr.size(); i++) begin
      if (i > 0)
        while ($urandom_range(99) < gap) begin
          in_valid = 1'b0; in_last = 1'($urandom); in_err = 1'($urandom);
          in_data = 8'($urandom);
          @(posedge clk); #1;
        end
      in_valid = 1'b1; in_data = fr[i];
      in_last = (i == fr.size() - 1); in_err = (i == err_at);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0; in_err = 1'b0;
  endtask

  task automatic check_queues(input string nm);
    chk($sformatf("%s_nout", nm), act_out.size(), exp_out.size());
    for (int i = 0; i < exp_out.size() && i < act_out.size(); i++) begin
      chk($sformatf("%s_out%0d_data", nm, i), act_out[i].d, exp_out[i].d);
      chk($sformatf("%s_out%0d_last", nm, i), act_out[i].last, exp_out[i].last);
    end
    chk($sformatf("%s_nstat", nm), act_st.size(), exp_st.size());
    for (int i = 0; i < exp_st.size() && i < act_st.size(); i++) begin
      chk($sformatf("%s_st%0d_crc_err", nm, i), act_st[i].crc_err, exp_st[i].crc_err);
      chk($sformatf("%s_st%0d_runt", nm, i), act_st[i].runt, exp_st[i].runt);
      chk($sformatf("%s_st%0d_oversize", nm, i), act_st[i].over, exp_st[i].over);
      chk($sformatf("%s_st%0d_phy_err", nm, i), act_st[i].phy, exp_st[i].phy);
      chk($sformatf("%s_st%0d_len", nm, i), act_st[i].len, exp_st[i].len);
    end
    exp_out.delete(); act_out.delete(); exp_st.delete(); act_st.delete();
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_out_valid"}, out_valid, 0);
    chk({nm, "_out_data"}, out_data, 0);
    chk({nm, "_out_last"}, out_last, 0);
    chk({nm, "_stat_valid"}, stat_valid, 0);
    chk({nm, "_stat_crc_err"}, stat_crc_err, 0);
    chk({nm, "_stat_runt"}, stat_runt, 0);
    chk({nm, "_stat_oversize"}, stat_oversize, 0);
    chk({nm, "_stat_phy_err"}, stat_phy_err, 0);
    chk({nm, "_stat_len"}, stat_len, 0);
  endtask

  // Collect everything the DUT emits, away from the active edge.
  ob_t mon_o;
  st_t mon_s;
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (out_valid) begin
        mon_o.d = out_data; mon_o.last = out_last;
        act_out.push_back(mon_o);
        if (out_last) chk("last_with_stat", stat_valid, 1);
      end
      if (stat_valid) begin
        mon_s.crc_err = stat_crc_err; mon_s.runt = stat_runt; mon_s.over = stat_oversize;
        mon_s.phy = stat_phy_err; mon_s.len = stat_len;
        act_st.push_back(mon_s);
      end
    end
  end

  initial begin
    st_t s;
    int n, err_at, gap;

    for (int i = 0; i < 256; i++) begin
      logic [31:0] c;
      c = 32'(i);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
      crc_tab[i] = c;
    end

    //          kind          n     err gap reps crc runt over phy len
    vt[0]  = '{K_DIGITS,      13,   -1, 0,  1,   0,  1,   0,   0,  13};
    vt[1]  = '{K_DIGITS_BAD,  13,   -1, 0,  1,   1,  1,   0,   0,  13};
    vt[2]  = '{K_ZERO,        64,   -1, 30, 2,   0,  0,   0,   0,  64};
    vt[3]  = '{K_RAW,         3,    -1, 0,  1,   1,  1,   0,   0,  3};
    vt[4]  = '{K_RAND,        1519, 99, 0,  1,   0,  0,   1,   1,  1519};
    vt[5]  = '{K_RAND,        64,   -1, 0,  1,   0,  0,   0,   0,  64};
    vt[6]  = '{K_RAND,        63,   -1, 0,  1,   0,  1,   0,   0,  63};
    vt[7]  = '{K_RAND,        1518, -1, 10, 1,   0,  0,   0,   0,  1518};
    vt[8]  = '{K_RAND,        5,    -1, 0,  1,   0,  1,   0,   0,  5};
    vt[9]  = '{K_RAND,        4,    -1, 0,  1,   0,  1,   0,   0,  4};
    vt[10] = '{K_RAND,        65,   64, 20, 1,   0,  0,   0,   1,  65};
    vt[11] = '{K_RAND,        4100, -1, 0,  1,   0,  0,   1,   0,  4095};

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; in_err = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    for (int v = 0; v < 12; v++) begin
      for (int r = 0; r < vt[v].reps; r++) begin
        build(vt[v].kind, vt[v].n);
        model_frame(vt[v].err_at >= 0, s);
        s.crc_err = 1'(vt[v].e_crc); s.runt = 1'(vt[v].e_runt);
        s.over = 1'(vt[v].e_over); s.phy = 1'(vt[v].e_phy); s.len = LEN_W'(vt[v].e_len);
        exp_st.push_back(s);
        drive_frame(vt[v].gap, vt[v].err_at);
      end
      idle(6);
      check_queues($sformatf("vec%0d", v));
    end

    // Reset in the middle of a frame: bytes already forwarded stay, no status.
    build(K_RAND, 64);
    for (int i = 0; i < 16; i++) begin
      mon_o.d = fr[i]; mon_o.last = 1'b0;
      exp_out.push_back(mon_o);
    end
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_data = fr[i]; in_last = 1'b0; in_err = 1'b0;
      @(posedge clk); #1;
    end
    idle(1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    check_queues("abort");
    build(K_RAND, 64);
    model_frame(1'b0, s);
    s.crc_err = 1'b0; s.runt = 1'b0; s.over = 1'b0; s.phy = 1'b0; s.len = LEN_W'(64);
    exp_st.push_back(s);
    drive_frame(0, -1);
    idle(6);
    check_queues("after_rst");

    // Random frames against the model.
    for (int f = 0; f < 40; f++) begin
      n = ($urandom_range(9) == 0) ? $urandom_range(1500, 1530) : $urandom_range(1, 100);
      if (n >= 4 && $urandom_range(4) != 0) build(K_RAND, n);
      else begin
        fr.delete();
        for (int i = 0; i < n; i++) fr.push_back(8'($urandom));
      end
      err_at = ($urandom_range(9) == 0) ? $urandom_range(n - 1) : -1;
      gap = $urandom_range(40);
      model_frame(err_at >= 0, s);
      exp_st.push_back(s);
      drive_frame(gap, err_at);
      if ($urandom_range(1) == 1) idle($urandom_range(1, 3));
    end
    idle(6);
    check_queues("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
